// File: rtl/mel_feature_sequencer_if.sv
// Mel feature sequencer bus: beat stream in, feature-memory write port out,
// classifier ownership handshake (feat_valid / feat_consumed).
// Latency: none (wires only). Backpressure: s_ready from the sequencer.
// Ports (modports):
//   master - upstream/classifier side: drives s_data, s_valid, feat_consumed.
//   slave  - sequencer side: drives s_ready, wr_*, frame_done, frame_idx, feat_valid.
interface mel_feature_sequencer_if #(
  parameter int BEAT_WIDTH = 20,
  parameter int ADDR_W     = 12
);
  logic [16*BEAT_WIDTH-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [16*BEAT_WIDTH-1:0] wr_data;
  logic                     frame_done;
  logic [5:0]               frame_idx;
  logic                     feat_valid;
  logic                     feat_consumed;

  modport master (
    output s_data, s_valid, feat_consumed,
    input  s_ready, wr_en, wr_addr, wr_data, frame_done, frame_idx, feat_valid
  );

  modport slave (
    input  s_data, s_valid, feat_consumed,
    output s_ready, wr_en, wr_addr, wr_data, frame_done, frame_idx, feat_valid
  );
endinterface

// File: rtl/mel_feature_sequencer.sv
// Sequences mel-energy beats into a frame-major feature memory and hands the
// finished window to the classifier. Latency: accept -> wr_en 1 cycle.
// Backpressure: s_ready high only while collecting; held low until release.
// Ports: clk, rst_n (async active-low); start_i, continuous_i, abort_i controls;
//   busy_o = not idle; bus (slave modport) carries beats, writes, feat handshake.
module mel_feature_sequencer #(
  parameter int BEAT_WIDTH = 20,
  parameter int N_BANKS    = 40,
  parameter int N_FRAMES   = 49,
  parameter int ADDR_W     = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic continuous_i,
  input  logic abort_i,
  output logic busy_o,
  mel_feature_sequencer_if.slave bus
);

  localparam int BPF = N_BANKS / BEAT_WIDTH;
  localparam int BCW = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int DW  = 16 * BEAT_WIDTH;

  if (N_FRAMES < 1 || N_FRAMES > 63) begin : g_bad_frames
    $error("mel_feature_sequencer: N_FRAMES must be 1..63");
  end
  if (BPF < 1 || (N_BANKS % BEAT_WIDTH) != 0) begin : g_bad_banks
    $error("mel_feature_sequencer: N_BANKS must be a multiple of BEAT_WIDTH");
  end
  if ((64'd1 << ADDR_W) < 64'(N_FRAMES * BPF)) begin : g_bad_addr
    $error("mel_feature_sequencer: ADDR_W too narrow for the window");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_READY   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [5:0]        frame_cnt_q, frame_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic [5:0]        frame_idx_q, frame_idx_d;

  logic              s_ready;
  logic              accept;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_addr;

  assign s_ready   = (state_q == S_COLLECT);
  assign accept    = bus.s_valid & s_ready;
  assign last_beat = (beat_cnt_q == BCW'(BPF - 1));
  assign beat_addr = ADDR_W'(frame_cnt_q) * ADDR_W'(BPF) + ADDR_W'(beat_cnt_q);

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_idx_d  = frame_idx_q;

    if (abort_i) begin
      // Abort wins over everything, including a beat accepted this cycle:
      // that beat is dropped and never written.
      state_d     = S_IDLE;
      beat_cnt_d  = '0;
      frame_cnt_d = '0;
      frame_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d     = S_COLLECT;
            beat_cnt_d  = '0;
            frame_cnt_d = '0;
            frame_idx_d = '0;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = beat_addr;
            wr_data_d   = bus.s_data;
            // Updated only on writes so it stays at N_FRAMES-1 once the
            // window is complete, even though frame_cnt moves past it.
            frame_idx_d = frame_cnt_q;
            if (last_beat) begin
              beat_cnt_d   = '0;
              frame_cnt_d  = frame_cnt_q + 6'd1;
              frame_done_d = 1'b1;
              if (frame_cnt_q == 6'(N_FRAMES - 1)) begin
                state_d = S_FLUSH;
              end
            end else begin
              beat_cnt_d = beat_cnt_q + BCW'(1);
            end
          end
        end
        S_FLUSH: begin
          // The registered write of the final beat is on the bus this cycle.
          state_d = S_READY;
        end
        S_READY: begin
          if (bus.feat_consumed) begin
            state_d     = continuous_i ? S_COLLECT : S_IDLE;
            beat_cnt_d  = '0;
            frame_cnt_d = '0;
            frame_idx_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_idx_q  <= frame_idx_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_idx  = frame_idx_q;
  assign bus.feat_valid = (state_q == S_READY);
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mel_feature_sequencer.sv
// Directed bench for mel_feature_sequencer at default parameters.
// Latency checked: accept -> write 1 cycle, final accept -> feat_valid 2 cycles.
// Backpressure checked: s_ready low outside COLLECT while s_valid is held.
module tb_mel_feature_sequencer;

  localparam int BW = 20;
  localparam int AW = 12;
  localparam int DW = 16 * BW;
  localparam int NW = 98;

  logic clk;
  logic rst_n;
  logic start;
  logic continuous;
  logic abort;
  logic busy;

  int cyc;
  int total;
  int bad;
  int fd_cnt;

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic          wf_q[$];
  logic [5:0]    wi_q[$];
  int            wc_q[$];
  int            ac_q[$];

  mel_feature_sequencer_if #(.BEAT_WIDTH(BW), .ADDR_W(AW)) bus ();

  mel_feature_sequencer #(
    .BEAT_WIDTH(BW), .N_BANKS(40), .N_FRAMES(49), .ADDR_W(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .continuous_i (continuous),
    .abort_i      (abort),
    .busy_o       (busy),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write log, sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      wf_q.push_back(bus.frame_done);
      wi_q.push_back(bus.frame_idx);
      wc_q.push_back(cyc);
    end
    if (bus.frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk_data(input int idx);
    logic [DW-1:0] d;
    d = '0;
    d[15:0]       = idx[15:0];
    d[DW-1:DW-16] = 16'hA000 ^ idx[15:0];
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs;
    wa_q.delete(); wd_q.delete(); wf_q.delete();
    wi_q.delete(); wc_q.delete(); ac_q.delete();
    fd_cnt = 0;
  endtask

  // Offers beats 0..n-1; with gaps, s_valid is random at 50%; with noise,
  // stray start / feat_consumed pulses are injected while collecting.
  task automatic feed(input int n, input bit gaps, input bit noise, output int got);
    int  idx;
    int  budget;
    int  c;
    bit  acc;
    idx = 0;
    budget = 0;
    while (idx < n && budget < 3000) begin
      bus.s_valid       = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.s_data        = mk_data(idx);
      start             = noise && ($urandom_range(0, 7) == 0);
      bus.feat_consumed = noise && ($urandom_range(0, 7) == 0);
      acc = bus.s_valid && bus.s_ready;
      c = cyc;
      tick;
      if (acc) begin
        ac_q.push_back(c);
        idx++;
      end
      budget++;
    end
    bus.s_valid = 1'b0;
    start = 1'b0;
    bus.feat_consumed = 1'b0;
    got = idx;
  endtask

  task automatic test_reset;
    int nrdy;
    rst_n = 1'b0;
    repeat (5) tick;
    total++; if (bus.wr_en !== 1'b0 || bus.frame_done !== 1'b0) begin bad++;
      $display("FAIL reset_strobes: wr_en=%b frame_done=%b want 0 0", bus.wr_en, bus.frame_done); end
    total++; if (bus.s_ready !== 1'b0 || busy !== 1'b0 || bus.feat_valid !== 1'b0) begin bad++;
      $display("FAIL reset_status: s_ready=%b busy=%b feat_valid=%b want 0 0 0", bus.s_ready, busy, bus.feat_valid); end
    total++; if (bus.wr_addr !== '0 || bus.wr_data !== '0 || bus.frame_idx !== 6'd0) begin bad++;
      $display("FAIL reset_regs: wr_addr=%0h frame_idx=%0d want 0 0", bus.wr_addr, bus.frame_idx); end
    rst_n = 1'b1;
    clear_logs();
    bus.s_valid = 1'b1;
    bus.s_data = mk_data(5);
    nrdy = 0;
    repeat (10) begin
      tick;
      if (bus.s_ready !== 1'b0) nrdy++;
    end
    bus.s_valid = 1'b0;
    total++; if (nrdy !== 0) begin bad++;
      $display("FAIL idle_ready: s_ready high %0d cycles, want 0", nrdy); end
    total++; if (wa_q.size() !== 0 || fd_cnt !== 0) begin bad++;
      $display("FAIL idle_writes: writes=%0d frame_done=%0d want 0 0", wa_q.size(), fd_cnt); end
    total++; if (busy !== 1'b0 || bus.feat_valid !== 1'b0) begin bad++;
      $display("FAIL idle_status: busy=%b feat_valid=%b want 0 0", busy, bus.feat_valid); end
  endtask

  task automatic test_full_window;
    int got;
    int ndone;
    clear_logs();
    start = 1'b1; tick; start = 1'b0;
    total++; if (busy !== 1'b1 || bus.s_ready !== 1'b1 || bus.feat_valid !== 1'b0) begin bad++;
      $display("FAIL start_collect: busy=%b s_ready=%b feat_valid=%b want 1 1 0", busy, bus.s_ready, bus.feat_valid); end
    feed(NW, 1'b0, 1'b0, got);
    total++; if (got !== NW) begin bad++;
      $display("FAIL full_accepts: got %0d beats want %0d", got, NW); end
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd97 || bus.frame_done !== 1'b1) begin bad++;
      $display("FAIL flush_write: wr_en=%b wr_addr=%0d frame_done=%b want 1 97 1", bus.wr_en, bus.wr_addr, bus.frame_done); end
    total++; if (bus.feat_valid !== 1'b0 || bus.s_ready !== 1'b0) begin bad++;
      $display("FAIL flush_status: feat_valid=%b s_ready=%b want 0 0", bus.feat_valid, bus.s_ready); end
    tick;
    total++; if (bus.feat_valid !== 1'b1 || bus.wr_en !== 1'b0 || bus.frame_idx !== 6'd48) begin bad++;
      $display("FAIL ready_status: feat_valid=%b wr_en=%b frame_idx=%0d want 1 0 48", bus.feat_valid, bus.wr_en, bus.frame_idx); end
    total++; if (wa_q.size() !== NW || ac_q.size() !== NW) begin bad++;
      $display("FAIL full_count: writes=%0d accepts=%0d want 98 98", wa_q.size(), ac_q.size()); end
    else begin
      ndone = 0;
      for (int i = 0; i < NW; i++) begin
        if (wf_q[i]) ndone++;
        total++; if (wa_q[i] !== AW'(i) || wd_q[i] !== mk_data(i)) begin bad++;
          $display("FAIL full_write[%0d]: addr=%0d data0=%0h want addr=%0d data0=%0h", i, wa_q[i], wd_q[i][15:0], i, i); end
        total++; if (wf_q[i] !== (i % 2 == 1) || wi_q[i] !== 6'(i / 2) || wc_q[i] !== ac_q[i] + 1) begin bad++;
          $display("FAIL full_meta[%0d]: frame_done=%b frame_idx=%0d lat=%0d want %b %0d 1", i, wf_q[i], wi_q[i], wc_q[i] - ac_q[i], (i % 2 == 1), i / 2); end
      end
      total++; if (ndone !== 49 || fd_cnt !== 49) begin bad++;
        $display("FAIL full_frame_done: pulses=%0d/%0d want 49", ndone, fd_cnt); end
    end
  endtask

  // Release with start and feat_consumed together, continuous=0.
  task automatic test_release_idle;
    continuous = 1'b0;
    bus.feat_consumed = 1'b1;
    start = 1'b1;
    tick;
    bus.feat_consumed = 1'b0;
    start = 1'b0;
    total++; if (busy !== 1'b0 || bus.feat_valid !== 1'b0 || bus.s_ready !== 1'b0) begin bad++;
      $display("FAIL release_idle: busy=%b feat_valid=%b s_ready=%b want 0 0 0", busy, bus.feat_valid, bus.s_ready); end
    tick;
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL release_start_ignored: busy=%b want 0", busy); end
  endtask

  task automatic test_gaps_and_rearm;
    int got;
    int nrdy;
    int bad_order;
    clear_logs();
    start = 1'b1; tick; start = 1'b0;
    feed(NW, 1'b1, 1'b1, got);
    total++; if (got !== NW) begin bad++;
      $display("FAIL gaps_accepts: got %0d beats want %0d", got, NW); end
    tick;
    total++; if (bus.feat_valid !== 1'b1) begin bad++;
      $display("FAIL gaps_ready: feat_valid=%b want 1", bus.feat_valid); end
    total++; if (wa_q.size() !== NW) begin bad++;
      $display("FAIL gaps_count: writes=%0d want 98", wa_q.size()); end
    else begin
      bad_order = 0;
      for (int i = 0; i < NW; i++)
        if (wa_q[i] !== AW'(i) || wd_q[i] !== mk_data(i) || wc_q[i] !== ac_q[i] + 1) bad_order++;
      total++; if (bad_order !== 0) begin bad++;
        $display("FAIL gaps_order: %0d writes out of order/wrong, want 0", bad_order); end
    end
    bus.s_valid = 1'b1;
    bus.s_data = mk_data(300);
    nrdy = 0;
    repeat (20) begin
      tick;
      if (bus.s_ready !== 1'b0) nrdy++;
    end
    total++; if (nrdy !== 0 || wa_q.size() !== NW || bus.feat_valid !== 1'b1) begin bad++;
      $display("FAIL ready_hold: s_ready cycles=%0d writes=%0d feat_valid=%b want 0 98 1", nrdy, wa_q.size(), bus.feat_valid); end
    continuous = 1'b1;
    bus.feat_consumed = 1'b1;
    bus.s_data = mk_data(500);
    tick;
    bus.feat_consumed = 1'b0;
    total++; if (busy !== 1'b1 || bus.s_ready !== 1'b1 || bus.feat_valid !== 1'b0) begin bad++;
      $display("FAIL rearm_state: busy=%b s_ready=%b feat_valid=%b want 1 1 0", busy, bus.s_ready, bus.feat_valid); end
    tick;
    bus.s_valid = 1'b0;
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd0 || bus.frame_idx !== 6'd0 || bus.wr_data !== mk_data(500)) begin bad++;
      $display("FAIL rearm_write: wr_en=%b wr_addr=%0d frame_idx=%0d want 1 0 0", bus.wr_en, bus.wr_addr, bus.frame_idx); end
    continuous = 1'b0;
    abort = 1'b1; tick; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL rearm_abort: busy=%b want 0", busy); end
  endtask

  task automatic test_abort;
    int got;
    clear_logs();
    start = 1'b1; tick; start = 1'b0;
    feed(37, 1'b0, 1'b0, got);
    bus.s_valid = 1'b1;
    bus.s_data = mk_data(37);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    bus.s_valid = 1'b0;
    total++; if (busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.feat_valid !== 1'b0) begin bad++;
      $display("FAIL abort_state: busy=%b s_ready=%b wr_en=%b feat_valid=%b want 0 0 0 0", busy, bus.s_ready, bus.wr_en, bus.feat_valid); end
    tick;
    total++; if (got !== 37 || wa_q.size() !== 37 || wa_q[$] !== 12'd36) begin bad++;
      $display("FAIL abort_drop: accepts=%0d writes=%0d last_addr=%0d want 37 37 36", got, wa_q.size(), wa_q[$]); end
    start = 1'b1; tick; start = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = mk_data(7);
    tick;
    bus.s_valid = 1'b0;
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd0 || bus.frame_idx !== 6'd0 || bus.wr_data !== mk_data(7)) begin bad++;
      $display("FAIL abort_restart: wr_en=%b wr_addr=%0d frame_idx=%0d want 1 0 0", bus.wr_en, bus.wr_addr, bus.frame_idx); end
    abort = 1'b1; tick; abort = 1'b0;
  endtask

  task automatic test_async_reset;
    int got;
    clear_logs();
    start = 1'b1; tick; start = 1'b0;
    feed(61, 1'b0, 1'b0, got);
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'd60 || bus.frame_idx !== 6'd30) begin bad++;
      $display("FAIL pre_reset_write: wr_en=%b wr_addr=%0d frame_idx=%0d want 1 60 30", bus.wr_en, bus.wr_addr, bus.frame_idx); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.wr_en !== 1'b0 || bus.frame_done !== 1'b0 || bus.s_ready !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL async_reset_ctl: wr_en=%b frame_done=%b s_ready=%b busy=%b want 0 0 0 0", bus.wr_en, bus.frame_done, bus.s_ready, busy); end
    total++; if (bus.wr_addr !== '0 || bus.wr_data !== '0 || bus.frame_idx !== 6'd0 || bus.feat_valid !== 1'b0) begin bad++;
      $display("FAIL async_reset_regs: wr_addr=%0d frame_idx=%0d feat_valid=%b want 0 0 0", bus.wr_addr, bus.frame_idx, bus.feat_valid); end
    clear_logs();
    bus.s_valid = 1'b1;
    tick; tick;
    #3 rst_n = 1'b1;
    repeat (5) tick;
    bus.s_valid = 1'b0;
    total++; if (wa_q.size() !== 0 || fd_cnt !== 0 || busy !== 1'b0) begin bad++;
      $display("FAIL post_reset_glitch: writes=%0d frame_done=%0d busy=%b want 0 0 0", wa_q.size(), fd_cnt, busy); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    fd_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    abort = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.feat_consumed = 1'b0;

    test_reset();
    test_full_window();
    test_release_idle();
    test_gaps_and_rearm();
    test_abort();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mel_feature_sequencer.md
Name: mel_feature_sequencer

Overview:
- Controller sitting downstream of the mel filter bank's output-reshaping stage.
- Accepts mel-energy beats of BEAT_WIDTH 16-bit words and sequences them into a frame-major feature memory of N_FRAMES x N_BANKS words.
- Signals the classifier when a full feature window is stored, then holds off the upstream until the classifier releases the buffer.
- Exerts backpressure upstream through s_ready.

Parameters:
- BEAT_WIDTH, 20, 16-bit words per input beat; N_BANKS must be an integer multiple of it.
- N_BANKS, 40, mel banks per frame.
- N_FRAMES, 49, frames per feature window.
- ADDR_W, 12, feature-memory beat-address width; must satisfy 2^ADDR_W >= N_FRAMES*N_BANKS/BEAT_WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins window collection.
- continuous  in  1  sampled at feat_consumed; 1 = rearm automatically.
- abort  in  1  synchronous; returns the block to IDLE.
- s_data  in  16*BEAT_WIDTH  beat data; word k is at bits [16k+15:16k].
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accept.
- wr_en  out  1  feature-memory write strobe.
- wr_addr  out  ADDR_W  beat address = frame*BPF + beat.
- wr_data  out  16*BEAT_WIDTH  registered copy of s_data.
- frame_done  out  1  one-cycle pulse with the last beat write of each frame.
- frame_idx  out  6  frame currently being written, 0..N_FRAMES-1.
- feat_valid  out  1  window complete, buffer owned by the classifier.
- feat_consumed  in  1  one-cycle pulse; classifier releases the buffer.
- busy  out  1  state != IDLE.

Behaviour:
- Definitions:
  - BPF = N_BANKS/BEAT_WIDTH (2 at defaults).
  - TOTAL = N_FRAMES*BPF (98 at defaults).
  - Beat accept = s_valid & s_ready.
- Reset (asynchronous, rst_n=0):
  - state = IDLE.
  - beat_cnt = 0, frame_cnt = 0.
  - s_ready, wr_en, frame_done, feat_valid, busy all = 0.
  - wr_addr = 0, wr_data = 0, frame_idx = 0.
  - Deasserting reset releases into IDLE with no spurious strobes.
- State IDLE:
  - s_ready = 0.
  - start -> COLLECT; counters cleared.
- State COLLECT:
  - s_ready = 1.
  - On each accept, next cycle: wr_en = 1, wr_addr = frame_cnt*BPF + beat_cnt, wr_data = s_data. Latency is exactly 1 cycle.
  - beat_cnt increments and wraps at BPF-1 -> 0.
  - On wrap, frame_cnt increments, and frame_done pulses together with that beat's wr_en.
  - Accept of beat TOTAL-1 -> FLUSH.
  - Back-to-back beats are sustained at 1 beat/clk; idle s_valid cycles are tolerated.
- State FLUSH (exactly 1 cycle):
  - s_ready = 0.
  - The final wr_en and frame_done are issued.
  - Next state READY.
- State READY:
  - s_ready = 0, feat_valid = 1.
  - feat_valid first rises 2 cycles after the final accept and 1 cycle after the final wr_en.
  - On feat_consumed: counters cleared, feat_valid drops next cycle. Next state is COLLECT if continuous = 1, else IDLE.
- frame_idx is a registered copy of frame_cnt and is aligned to wr_addr. After the window completes it holds N_FRAMES-1 until the counters clear.
- Priority and corner cases:
  - abort > feat_consumed > start.
  - abort in any state: next cycle IDLE, counters = 0, feat_valid = 0, s_ready = 0. An accept in the abort cycle is dropped: no wr_en.
  - start while busy is ignored.
  - feat_consumed outside READY is ignored.
  - start and feat_consumed in the same cycle while in READY: feat_consumed governs; start is ignored.
  - s_valid in IDLE, FLUSH or READY: not accepted; the upstream must hold its data.
  - rst_n asserted mid-window: immediate IDLE, all outputs go to their reset values asynchronously.
- Arithmetic:
  - wr_addr is computed in ADDR_W bits, unsigned, with no wrap inside a window.
  - beat_cnt width = clog2(BPF), minimum 1.
  - frame_cnt is 6 bits; N_FRAMES <= 63 is enforced by an elaboration-time check.

Test Plan:
- Reset/idle: hold rst_n=0 for 5 clk, then release; drive s_valid=1 with no start -> s_ready=0, wr_en never 1, busy=0, feat_valid=0.
- Full window, defaults: start, then 98 back-to-back beats carrying s_data word0 = beat index ->
  - wr_addr sequence 0..97, each write 1 cycle after its accept.
  - frame_done on addresses 1,3,...,97 (49 pulses).
  - feat_valid=1 two cycles after beat 97 is accepted.
- Backpressure/gaps: random s_valid at 50% duty -> same 98 writes in order and no duplicates; s_ready=0 in READY while s_valid is held for 20 cycles.
- Release modes:
  - In READY with continuous=0, pulse feat_consumed -> IDLE, busy=0.
  - With continuous=1 -> COLLECT next cycle; next write has wr_addr=0, frame_idx=0.
- Abort mid-frame: abort concurrent with the accept of beat 37 -> no write for beat 37, IDLE next cycle; a later start restarts at wr_addr=0.
- Async reset mid-window: rst_n low between clock edges at beat 60 -> outputs 0 immediately, with no wr_en or frame_done glitch after release.
